// File: rtl/ascon_ti_pkg.sv
// Shared constants, types and the unmasked reference model for the masked Ascon
// substitution layer.
package ascon_ti_pkg;

   localparam int NSHARES    = 3;
   localparam int NLANES     = 5;
   localparam int MAX_LANE_W = 64;

   // One unmasked 5-bit S-box column, x0 in the MSB.
   typedef logic [NLANES-1:0] sbox_word_t;

   // Widest share vector (five lanes of MAX_LANE_W bits).
   typedef logic [NLANES*MAX_LANE_W-1:0] share_vec_t;

   function automatic sbox_word_t ascon_sbox_ref(input sbox_word_t w);
      logic x0, x1, x2, x3, x4;
      logic t0, t1, t2, t3, t4;
      {x0, x1, x2, x3, x4} = w;
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      return {x0, x1, x2, x3, x4};
   endfunction

endpackage

// File: rtl/ascon_ti_share_fn.sv
// Component function F<SHARE_IDX> of the 3-share Ascon S-box TI. It only sees
// the two neighbouring input shares, so non-completeness holds by construction.
module ascon_ti_share_fn
   import ascon_ti_pkg::*;
#(
   parameter int SHARE_IDX = 0,
   parameter int LANE_W    = 64
) (
   input  logic [NLANES*LANE_W-1:0] sa,   // input share (SHARE_IDX+1) mod 3
   input  logic [NLANES*LANE_W-1:0] sb,   // input share (SHARE_IDX+2) mod 3
   output logic [NLANES*LANE_W-1:0] y
);

   typedef logic [NLANES-1:0][LANE_W-1:0] lanes_t;

   function automatic lanes_t pre_lin(input lanes_t v);
      lanes_t r = v;
      r[0] = v[0] ^ v[4];
      r[4] = v[4] ^ v[3];
      r[2] = v[2] ^ v[1];
      return r;
   endfunction

   function automatic lanes_t post_lin(input lanes_t v);
      lanes_t r = v;
      r[1] = v[1] ^ v[0];
      r[0] = v[0] ^ v[4];
      r[3] = v[3] ^ v[2];
      return r;
   endfunction

   lanes_t p, q, chi, post;

   assign p = pre_lin(sa);
   assign q = pre_lin(sb);

   // (~b & c) = c ^ b&c; the three cross-product shares together cover every b_i*c_j.
   always_comb begin
      chi = '0;
      for (int i = 0; i < NLANES; i++) begin
         chi[i] = p[i] ^ p[(i+2)%NLANES]
                ^ (p[(i+1)%NLANES] & p[(i+2)%NLANES])
                ^ (p[(i+1)%NLANES] & q[(i+2)%NLANES])
                ^ (q[(i+1)%NLANES] & p[(i+2)%NLANES]);
      end
   end

   assign post = post_lin(chi);

   always_comb begin
      y = post;
      if (SHARE_IDX == 2) y[2*LANE_W +: LANE_W] = ~post[2];
   end

endmodule

// File: rtl/ascon_sbox_ti_pipe.sv
// Two-stage pipelined 3-share Ascon S-box layer with optional share refresh
// and valid/ready flow control.
module ascon_sbox_ti_pipe
   import ascon_ti_pkg::*;
#(
   parameter int LANE_W     = 64,
   parameter bit REFRESH_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NLANES*LANE_W-1:0] x_s0,
   input  logic [NLANES*LANE_W-1:0] x_s1,
   input  logic [NLANES*LANE_W-1:0] x_s2,
   input  logic                     rnd_valid,
   output logic                     rnd_ready,
   input  logic [2*NLANES*LANE_W-1:0] rnd_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NLANES*LANE_W-1:0] y_s0,
   output logic [NLANES*LANE_W-1:0] y_s1,
   output logic [NLANES*LANE_W-1:0] y_s2
);

   localparam int SW = NLANES * LANE_W;

   logic [NSHARES-1:0][SW-1:0] f, reg_a, reg_b, refreshed;
   logic [SW-1:0]              ra, rb;
   logic                       valid_a, valid_b, adv_b, accept;

   ascon_ti_share_fn #(.SHARE_IDX(0), .LANE_W(LANE_W)) u_f0 (.sa(x_s1), .sb(x_s2), .y(f[0]));
   ascon_ti_share_fn #(.SHARE_IDX(1), .LANE_W(LANE_W)) u_f1 (.sa(x_s2), .sb(x_s0), .y(f[1]));
   ascon_ti_share_fn #(.SHARE_IDX(2), .LANE_W(LANE_W)) u_f2 (.sa(x_s0), .sb(x_s1), .y(f[2]));

   assign adv_b     = valid_a & (~valid_b | out_ready) & (rnd_valid | ~REFRESH_EN);
   assign in_ready  = ~valid_a | adv_b;
   assign rnd_ready = adv_b & REFRESH_EN;
   assign accept    = in_valid & in_ready;

   // Without refresh the mask words are forced to zero, so stage B is a plain copy.
   assign ra = REFRESH_EN ? rnd_i[0  +: SW] : '0;
   assign rb = REFRESH_EN ? rnd_i[SW +: SW] : '0;

   assign refreshed[0] = reg_a[0] ^ ra;
   assign refreshed[1] = reg_a[1] ^ rb;
   assign refreshed[2] = reg_a[2] ^ ra ^ rb;

   // NOTE: share registers are reset too, so y_s* is all-zero out of reset rather than X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_a <= 1'b0;
         valid_b <= 1'b0;
         reg_a   <= '0;
         reg_b   <= '0;
      end else begin
         valid_a <= accept | (valid_a & ~adv_b);
         valid_b <= adv_b | (valid_b & ~out_ready);
         if (accept) reg_a <= f;
         if (adv_b)  reg_b <= refreshed;
      end
   end

   assign out_valid = valid_b;
   assign y_s0      = reg_b[0];
   assign y_s1      = reg_b[1];
   assign y_s2      = reg_b[2];

endmodule

// File: tb/tb_ascon_sbox_ti_pipe.sv
// Directed and randomized bench for ascon_sbox_ti_pipe: a 64-lane refreshing build
// and a 1-lane non-refreshing build, checked against a hand-entered S-box table.
module tb_ascon_sbox_ti_pipe;
   import ascon_ti_pkg::*;

   localparam int W  = 64;
   localparam int SW = NLANES * W;

   localparam logic [4:0] SBOX_T [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
   logic [SW-1:0]   x_s0, x_s1, x_s2, y_s0, y_s1, y_s2;
   logic [2*SW-1:0] rnd_i;

   logic            in_valid1, in_ready1, rnd_valid1, rnd_ready1, out_valid1, out_ready1;
   logic [4:0]      x1_s0, x1_s1, x1_s2, y1_s0, y1_s1, y1_s2;
   logic [9:0]      rnd1;

   int              n_cmp = 0, n_bad = 0, n_in = 0, n_out = 0;
   logic            acc_flag, prev_stall;
   logic [SW-1:0]   prev_y0, prev_y1, prev_y2;
   logic [SW-1:0]   exp_q [$];

   always #5 clk = ~clk;

   ascon_sbox_ti_pipe #(.LANE_W(W), .REFRESH_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_s0(x_s0), .x_s1(x_s1), .x_s2(x_s2), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .rnd_i(rnd_i), .out_valid(out_valid), .out_ready(out_ready),
      .y_s0(y_s0), .y_s1(y_s1), .y_s2(y_s2));

   ascon_sbox_ti_pipe #(.LANE_W(1), .REFRESH_EN(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .x_s0(x1_s0), .x_s1(x1_s1), .x_s2(x1_s2), .rnd_valid(rnd_valid1), .rnd_ready(rnd_ready1),
      .rnd_i(rnd1), .out_valid(out_valid1), .out_ready(out_ready1),
      .y_s0(y1_s0), .y_s1(y1_s1), .y_s2(y1_s2));

   task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] model(input logic [SW-1:0] x, input int w);
      logic [SW-1:0] y;
      logic [4:0]    s, r;
      y = '0;
      for (int k = 0; k < w; k++) begin
         for (int i = 0; i < 5; i++) s[4-i] = x[i*w+k];
         r = SBOX_T[s];
         for (int i = 0; i < 5; i++) y[i*w+k] = r[4-i];
      end
      return y;
   endfunction

   function automatic logic [SW-1:0] rand_sw();
      logic [SW-1:0] r;
      for (int i = 0; i < SW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [2*SW-1:0] rand_rnd();
      logic [2*SW-1:0] r;
      for (int i = 0; i < 2*SW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic drive_rand();
      x_s0 = rand_sw();
      x_s1 = rand_sw();
      x_s2 = rand_sw();
   endtask

   // One clock of the 64-lane DUT: observe handshakes, score outputs, advance to next negedge.
   task automatic step();
      #1;
      if (!rnd_valid) check_bit("rnd_ready_idle", rnd_ready, 1'b0);
      if (prev_stall) begin
         check("hold_s0", y_s0, prev_y0);
         check("hold_s1", y_s1, prev_y1);
         check("hold_s2", y_s2, prev_y2);
      end
      if (out_valid && out_ready) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_bad++;
            $error("FAIL out_unexpected: observed output %h, required none", y_s0 ^ y_s1 ^ y_s2);
         end
         if (exp_q.size() > 0) check("out_data", y_s0 ^ y_s1 ^ y_s2, exp_q.pop_front());
         n_out++;
      end
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
         exp_q.push_back(model(x_s0 ^ x_s1 ^ x_s2, W));
         n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y0 = y_s0;
      prev_y1 = y_s1;
      prev_y2 = y_s2;
      @(negedge clk);
   endtask

   initial begin
      logic [SW-1:0]   e, xs, ya0, ya1, ya2;
      logic [2*SW-1:0] r1;
      int              sent, out0, fuzz_acc;

      rst_n = 1'b0;   in_valid = 1'b0;  rnd_valid = 1'b1;  out_ready = 1'b1;
      x_s0 = '0;      x_s1 = '0;        x_s2 = '0;         rnd_i = '0;
      in_valid1 = 1'b0; rnd_valid1 = 1'b0; out_ready1 = 1'b1;
      x1_s0 = '0;     x1_s1 = '0;       x1_s2 = '0;        rnd1 = '0;
      prev_stall = 1'b0; acc_flag = 1'b0;

      // Reset state
      #1;
      check_bit("rst_in_ready", in_ready, 1'b1);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_rnd_ready", rnd_ready, 1'b0);
      check("rst_y_s0", y_s0, '0);
      check("rst_y_s1", y_s1, '0);
      check("rst_y_s2", y_s2, '0);
      check_bit("rst_w1_out_valid", out_valid1, 1'b0);
      check("rst_w1_y", SW'(y1_s0 | y1_s1 | y1_s2), '0);

      // Package reference model against the hand table
      for (int v = 0; v < 32; v++)
         check("pkg_sbox_ref", SW'(ascon_sbox_ref(5'(v))), SW'(SBOX_T[v]));

      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Known answer: all-zero input, zero masks
      rnd_i = rand_rnd(); in_valid = 1'b1;
      in_valid1 = 1'b1; rnd1 = 10'h3a5;
      #1;
      check_bit("ka0_in_ready", in_ready, 1'b1);
      check_bit("ka0_w1_in_ready", in_ready1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; in_valid1 = 1'b0;
      #1;
      check_bit("ka0_lat1", out_valid, 1'b0);
      check_bit("ka0_rnd_ready", rnd_ready, 1'b1);
      check_bit("ka0_w1_rnd_ready", rnd_ready1, 1'b0);
      @(negedge clk);
      #1;
      e = '0; e[2*W +: W] = '1;
      check_bit("ka0_valid", out_valid, 1'b1);
      check("ka0_y", y_s0 ^ y_s1 ^ y_s2, e);
      check_bit("ka0_w1_valid", out_valid1, 1'b1);
      check("ka0_w1_y", SW'(y1_s0 ^ y1_s1 ^ y1_s2), SW'(5'b00100));
      @(negedge clk);

      // Known answer: x4 all ones under random masks
      xs = '0; xs[4*W +: W] = '1;
      x_s1 = rand_sw(); x_s2 = rand_sw(); x_s0 = xs ^ x_s1 ^ x_s2;
      rnd_i = rand_rnd(); in_valid = 1'b1;
      x1_s1 = 5'b01101; x1_s2 = 5'b10110; x1_s0 = 5'b10000 ^ x1_s1 ^ x1_s2;
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_valid1 = 1'b0;
      #1;
      check_bit("ka1_lat1", out_valid, 1'b0);
      @(negedge clk);
      #1;
      e = '0; e[1*W +: W] = '1; e[3*W +: W] = '1; e[4*W +: W] = '1;
      check_bit("ka1_valid", out_valid, 1'b1);
      check("ka1_y", y_s0 ^ y_s1 ^ y_s2, e);
      check_bit("ka1_w1_valid", out_valid1, 1'b1);
      check("ka1_w1_y", SW'(y1_s0 ^ y1_s1 ^ y1_s2), SW'(5'b11010));
      @(negedge clk);

      // Randomness starvation with stage A full
      rnd_valid = 1'b0; drive_rand(); xs = x_s0 ^ x_s1 ^ x_s2; in_valid = 1'b1;
      #1;
      check_bit("starve_accept", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_bit("starve_rnd_ready", rnd_ready, 1'b0);
         check_bit("starve_in_ready", in_ready, 1'b0);
         check_bit("starve_no_adv", out_valid, 1'b0);
         @(negedge clk);
      end
      r1 = rand_rnd(); rnd_i = r1; rnd_valid = 1'b1;
      #1;
      check_bit("starve_resume", rnd_ready, 1'b1);
      @(negedge clk);
      #1;
      check_bit("starve_out", out_valid, 1'b1);
      ya0 = y_s0; ya1 = y_s1; ya2 = y_s2;
      check("starve_y", ya0 ^ ya1 ^ ya2, model(xs, W));
      @(negedge clk);

      // Same shares, different randomness
      rnd_i = r1 ^ {{SW{1'b1}}, {(SW/2){2'b01}}}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check_bit("rnd2_out", out_valid, 1'b1);
      check_bit("rnd2_s0_diff", y_s0 != ya0, 1'b1);
      check_bit("rnd2_s1_diff", y_s1 != ya1, 1'b1);
      check_bit("rnd2_s2_diff", y_s2 != ya2, 1'b1);
      check("rnd2_y", y_s0 ^ y_s1 ^ y_s2, ya0 ^ ya1 ^ ya2);
      @(negedge clk);

      // Backpressure: six samples, out_ready low for five cycles
      prev_stall = 1'b0; out0 = n_out; sent = 0;
      out_ready = 1'b0; rnd_valid = 1'b1;
      drive_rand(); in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (acc_flag) begin sent++; drive_rand(); end
      end
      #1;
      check("bp_accepts", SW'(sent), SW'(2));
      check_bit("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      for (int c = 0; c < 40 && !(sent == 6 && exp_q.size() == 0); c++) begin
         in_valid = (sent < 6);
         step();
         if (acc_flag) begin sent++; drive_rand(); end
      end
      in_valid = 1'b0;
      check("bp_drained", SW'(n_out - out0), SW'(6));

      // Random fuzz with random flow control
      fuzz_acc = 0;
      for (int c = 0; c < 60000 && fuzz_acc < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rnd_valid = ($urandom_range(0, 3) != 0);
         drive_rand();
         rnd_i = rand_rnd();
         step();
         if (acc_flag) fuzz_acc++;
      end
      in_valid = 1'b0; out_ready = 1'b1; rnd_valid = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
      check("fuzz_accepts", SW'(fuzz_acc), SW'(10000));
      check("fuzz_in_eq_out", SW'(n_in), SW'(n_out));

      // Reset with both stages occupied
      out_ready = 1'b0; in_valid = 1'b1; drive_rand();
      step();
      drive_rand();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("mid_rst_out_valid", out_valid, 1'b0);
      check_bit("mid_rst_in_ready", in_ready, 1'b1);
      check_bit("mid_rst_rnd_ready", rnd_ready, 1'b0);
      check("mid_rst_y", y_s0 | y_s1 | y_s2, '0);
      exp_q.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      out0 = n_out;
      repeat (5) step();
      check("mid_rst_no_out", SW'(n_out - out0), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
